// File: rtl/pwm_meter.sv
// pwm_meter: measures high time and period of each complete cycle of an asynchronous PWM line.
// Optional feature macro PWM_METER_TIMEOUT_EN: flags a line held static until the period count saturates.
module pwm_meter #(
    parameter int CNT_W       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             ovf,
    output logic             duty_inc,
    output logic             duty_dec,
    output logic             stuck,
    output logic             stuck_level
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (v == CNT_MAX) begin
            res = CNT_MAX;
        end else begin
            res = v + CNT_ONE;
        end
        return res;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   lvl_s;
    logic                   rise_s;
    logic                   fall_s;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       hacc_r;
    logic [CNT_W-1:0]       hacc_nxt_s;
    logic [CNT_W-1:0]       hacc_inc_s;
    logic [CNT_W-1:0]       pacc_r;
    logic [CNT_W-1:0]       pacc_nxt_s;
    logic [CNT_W-1:0]       pacc_inc_s;
    logic                   sat_r;
    logic                   sat_nxt_s;
    logic                   first_r;
    logic                   first_nxt_s;
    logic                   publish_s;
    logic                   inc_s;
    logic                   dec_s;

    logic [CNT_W-1:0]       high_cnt_r;
    logic [CNT_W-1:0]       period_cnt_r;
    logic                   meas_valid_r;
    logic                   ovf_r;
    logic                   duty_inc_r;
    logic                   duty_dec_r;

`ifdef PWM_METER_TIMEOUT_EN
    logic                   stuck_r;
    logic                   stuck_nxt_s;
    logic                   stuck_level_r;
    logic                   stuck_level_nxt_s;
    logic                   timeout_s;
`endif

    // Input synchronizer and edge history, preset high so a line already high at reset gives no rise
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign lvl_s      = sync_r[SYNC_STAGES-1];
    assign rise_s     = lvl_s & ~prev_r;
    assign fall_s     = ~lvl_s & prev_r;
    assign hacc_inc_s = sat_inc(hacc_r);
    assign pacc_inc_s = sat_inc(pacc_r);
    assign inc_s      = ~first_r & (hacc_r > high_cnt_r);
    assign dec_s      = ~first_r & (hacc_r < high_cnt_r);

    // Measurement FSM: next state, accumulator updates and publish decision
    always_comb begin
        state_nxt_s = state_r;
        hacc_nxt_s  = hacc_r;
        pacc_nxt_s  = pacc_r;
        sat_nxt_s   = sat_r;
        first_nxt_s = first_r;
        publish_s   = 1'b0;
`ifdef PWM_METER_TIMEOUT_EN
        stuck_nxt_s       = stuck_r;
        stuck_level_nxt_s = stuck_level_r;
        timeout_s         = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_nxt_s = ST_HIGH;
                    hacc_nxt_s  = CNT_ONE;
                    pacc_nxt_s  = CNT_ONE;
                    sat_nxt_s   = 1'b0;
`ifdef PWM_METER_TIMEOUT_EN
                    stuck_nxt_s       = 1'b0;
                    stuck_level_nxt_s = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (fall_s) begin
                    state_nxt_s = ST_LOW;
                    pacc_nxt_s  = pacc_inc_s;
                    sat_nxt_s   = sat_r | (pacc_inc_s == CNT_MAX);
                end else begin
                    hacc_nxt_s = hacc_inc_s;
                    pacc_nxt_s = pacc_inc_s;
                    sat_nxt_s  = sat_r | (hacc_inc_s == CNT_MAX) | (pacc_inc_s == CNT_MAX);
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    publish_s   = 1'b1;
                    state_nxt_s = ST_HIGH;
                    hacc_nxt_s  = CNT_ONE;
                    pacc_nxt_s  = CNT_ONE;
                    sat_nxt_s   = 1'b0;
                    first_nxt_s = 1'b0;
                end else begin
                    pacc_nxt_s = pacc_inc_s;
                    sat_nxt_s  = sat_r | (pacc_inc_s == CNT_MAX);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                hacc_nxt_s  = CNT_ZERO;
                pacc_nxt_s  = CNT_ZERO;
                sat_nxt_s   = 1'b0;
                first_nxt_s = 1'b1;
            end
        endcase
`ifdef PWM_METER_TIMEOUT_EN
        // A period count about to saturate means the line has stopped toggling
        timeout_s         = (state_r != ST_IDLE) && !publish_s && (pacc_nxt_s == CNT_MAX);
        state_nxt_s       = timeout_s ? ST_IDLE : state_nxt_s;
        first_nxt_s       = timeout_s ? 1'b1 : first_nxt_s;
        stuck_nxt_s       = timeout_s ? 1'b1 : stuck_nxt_s;
        stuck_level_nxt_s = timeout_s ? lvl_s : stuck_level_nxt_s;
`endif
    end

    // FSM state and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            hacc_r  <= CNT_ZERO;
            pacc_r  <= CNT_ZERO;
            sat_r   <= 1'b0;
            first_r <= 1'b1;
`ifdef PWM_METER_TIMEOUT_EN
            stuck_r       <= 1'b0;
            stuck_level_r <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            hacc_r  <= hacc_nxt_s;
            pacc_r  <= pacc_nxt_s;
            sat_r   <= sat_nxt_s;
            first_r <= first_nxt_s;
`ifdef PWM_METER_TIMEOUT_EN
            stuck_r       <= stuck_nxt_s;
            stuck_level_r <= stuck_level_nxt_s;
`endif
        end
    end

    // Published measurement registers, held between publishes
    always_ff @(posedge clk) begin
        if (rst) begin
            high_cnt_r   <= CNT_ZERO;
            period_cnt_r <= CNT_ZERO;
            meas_valid_r <= 1'b0;
            ovf_r        <= 1'b0;
            duty_inc_r   <= 1'b0;
            duty_dec_r   <= 1'b0;
        end else begin
            meas_valid_r <= publish_s;
            if (publish_s) begin
                high_cnt_r   <= hacc_r;
                period_cnt_r <= pacc_r;
                ovf_r        <= sat_r;
                duty_inc_r   <= inc_s;
                duty_dec_r   <= dec_s;
            end
        end
    end

    assign high_cnt   = high_cnt_r;
    assign period_cnt = period_cnt_r;
    assign meas_valid = meas_valid_r;
    assign ovf        = ovf_r;
    assign duty_inc   = duty_inc_r;
    assign duty_dec   = duty_dec_r;
`ifdef PWM_METER_TIMEOUT_EN
    assign stuck       = stuck_r;
    assign stuck_level = stuck_level_r;
`else
    assign stuck       = 1'b0;
    assign stuck_level = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_meter.sv
// Self-checking bench for pwm_meter: three instances (sync depth 2 and 4, narrow counter) on one PWM line,
// checked every cycle against a model built from the sampled line's edge positions.
module tb_pwm_meter;

`ifdef PWM_METER_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif
    localparam int HIST = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm_in = 1'b0;

    logic [11:0] hc0, pc0, hc1, pc1;
    logic [5:0]  hc2, pc2;
    logic [2:0]  mv, ov, di, dd, stk, stl;

    always #5 clk = ~clk;

    pwm_meter #(.CNT_W(12), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .high_cnt(hc0), .period_cnt(pc0),
        .meas_valid(mv[0]), .ovf(ov[0]), .duty_inc(di[0]), .duty_dec(dd[0]),
        .stuck(stk[0]), .stuck_level(stl[0]));
    pwm_meter #(.CNT_W(12), .SYNC_STAGES(4)) u1 (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .high_cnt(hc1), .period_cnt(pc1),
        .meas_valid(mv[1]), .ovf(ov[1]), .duty_inc(di[1]), .duty_dec(dd[1]),
        .stuck(stk[1]), .stuck_level(stl[1]));
    pwm_meter #(.CNT_W(6), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .high_cnt(hc2), .period_cnt(pc2),
        .meas_valid(mv[2]), .ovf(ov[2]), .duty_inc(di[2]), .duty_dec(dd[2]),
        .stuck(stk[2]), .stuck_level(stl[2]));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rst = -1;
    bit model_on = 1'b0;
    bit cap_en = 1'b0;
    bit samp [HIST];
    int lat0, lat1;

    // model state per instance
    int exp_hc [3], exp_pc [3];
    bit exp_mv [3], exp_ovf [3], exp_inc [3], exp_dec [3], exp_stk [3], exp_stl [3];
    bit meas [3], first [3];
    int rs [3], fs [3];

    int q_hc [$], q_pc [$], q_inc [$], q_dec [$], q_t [$];

    function automatic int stages(input int i);
        return (i == 1) ? 4 : 2;
    endfunction

    function automatic int maxv(input int i);
        return (i == 2) ? 63 : 4095;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // line level as the DUT sees it: everything up to the last reset edge reads high
    function automatic bit lv(input int j);
        if (j < 0 || j <= last_rst || j >= HIST) return 1'b1;
        return samp[j];
    endfunction

    function automatic int act_hc(input int i);
        case (i)
            0: return int'(hc0);
            1: return int'(hc1);
            default: return int'(hc2);
        endcase
    endfunction

    function automatic int act_pc(input int i);
        case (i)
            0: return int'(pc0);
            1: return int'(pc1);
            default: return int'(pc2);
        endcase
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%0d expected=%0d", nm, idx, cyc, act, expv);
        end
    endtask

    // Model: a rise sampled at index r is acted on SYNC_STAGES edges later; H/P are index differences
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < HIST) samp[cyc] = pwm_in;
        if (rst) begin
            last_rst = cyc;
            model_on = 1'b1;
            for (int i = 0; i < 3; i++) begin
                exp_hc[i] = 0; exp_pc[i] = 0; exp_mv[i] = 1'b0; exp_ovf[i] = 1'b0;
                exp_inc[i] = 1'b0; exp_dec[i] = 1'b0; exp_stk[i] = 1'b0; exp_stl[i] = 1'b0;
                meas[i] = 1'b0; first[i] = 1'b1; rs[i] = 0; fs[i] = -1;
            end
        end else if (model_on) begin
            for (int i = 0; i < 3; i++) begin
                int r, p, h, hp, pp;
                bit rise, fall;
                r = cyc - stages(i);
                rise = lv(r) && !lv(r - 1);
                fall = !lv(r) && lv(r - 1);
                exp_mv[i] = 1'b0;
                if (meas[i]) begin
                    if (fall) fs[i] = r;
                    if (rise) begin
                        p = r - rs[i];
                        h = fs[i] - rs[i];
                        hp = imin(h, maxv(i));
                        pp = imin(p, maxv(i));
                        exp_inc[i] = !first[i] && (hp > exp_hc[i]);
                        exp_dec[i] = !first[i] && (hp < exp_hc[i]);
                        exp_hc[i] = hp;
                        exp_pc[i] = pp;
                        exp_ovf[i] = (p >= maxv(i));
                        exp_mv[i] = 1'b1;
                        first[i] = 1'b0;
                        rs[i] = r;
                        fs[i] = -1;
                    end else if (TMO && (r - rs[i] == maxv(i) - 1)) begin
                        meas[i] = 1'b0;
                        first[i] = 1'b1;
                        exp_stk[i] = 1'b1;
                        exp_stl[i] = lv(r);
                    end
                end else if (rise) begin
                    meas[i] = 1'b1;
                    rs[i] = r;
                    fs[i] = -1;
                    exp_stk[i] = 1'b0;
                    exp_stl[i] = 1'b0;
                end
            end
        end
    end

    task automatic drive(input bit level, input int n);
        pwm_in = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm_cycle(input int h, input int p);
        drive(1'b1, h);
        drive(1'b0, p - h);
    endtask

    initial begin
        // every-cycle comparison against the model, plus capture of instance 0 publishes
        fork
            forever begin
                @(negedge clk);
                if (model_on) begin
                    for (int i = 0; i < 3; i++) begin
                        chk("high_cnt", i, act_hc(i), exp_hc[i]);
                        chk("period_cnt", i, act_pc(i), exp_pc[i]);
                        chk("meas_valid", i, int'(mv[i]), int'(exp_mv[i]));
                        chk("ovf", i, int'(ov[i]), int'(exp_ovf[i]));
                        chk("duty_inc", i, int'(di[i]), int'(exp_inc[i]));
                        chk("duty_dec", i, int'(dd[i]), int'(exp_dec[i]));
                        chk("stuck", i, int'(stk[i]), int'(exp_stk[i]));
                        chk("stuck_level", i, int'(stl[i]), int'(exp_stl[i]));
                    end
                end
                if (cap_en && mv[0]) begin
                    q_hc.push_back(int'(hc0));
                    q_pc.push_back(int'(pc0));
                    q_inc.push_back(int'(di[0]));
                    q_dec.push_back(int'(dd[0]));
                    q_t.push_back(cyc);
                end
            end
        join_none

        // reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_high_cnt", i, act_hc(i), 0);
            chk("rst_period_cnt", i, act_pc(i), 0);
            chk("rst_meas_valid", i, int'(mv[i]), 0);
            chk("rst_flags", i, int'({ov[i], di[i], dd[i], stk[i], stl[i]}), 0);
        end
        rst = 1'b0;

        // steady 10/16, last cycle also measures strobe latency for both sync depths
        repeat (6) pwm_cycle(10, 16);
        lat0 = 0;
        lat1 = 0;
        pwm_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mv[0] && lat0 == 0) lat0 = k;
            if (mv[1] && lat1 == 0) lat1 = k;
        end
        chk("latency_s2", 0, lat0, 3);
        chk("latency_s4", 1, lat1, 5);
        chk("latency_shift", 1, lat1 - lat0, 2);
        chk("steady_high", 0, int'(hc0), 10);
        chk("steady_period", 0, int'(pc0), 16);
        chk("steady_high", 1, int'(hc1), 10);
        chk("steady_period", 1, int'(pc1), 16);
        chk("steady_dir", 0, int'({di[0], dd[0], ov[0]}), 0);
        drive(1'b0, 6);

        // reset asserted mid-HIGH with the line high; release with the line still high
        drive(1'b1, 5);
        rst = 1'b1;
        drive(1'b1, 2);
        chk("midrst_high_cnt", 0, int'(hc0), 0);
        chk("midrst_period_cnt", 1, int'(pc1), 0);
        chk("midrst_outputs", 0, int'({mv[0], ov[0], di[0], dd[0]}), 0);
        rst = 1'b0;
        q_hc.delete(); q_pc.delete(); q_inc.delete(); q_dec.delete(); q_t.delete();
        cap_en = 1'b1;
        drive(1'b1, 4);
        drive(1'b0, 3);

        // ramp up, one step down, then the extremes
        for (int h = 1; h <= 15; h++) pwm_cycle(h, 16);
        pwm_cycle(14, 16);
        repeat (4) pwm_cycle(1, 2);
        repeat (3) pwm_cycle(15, 16);

        // line held high for 100 cycles, then toggled
        drive(1'b1, 90);
        chk("hold_high", 0, int'(hc0), 15);
        chk("hold_period", 0, int'(pc0), 16);
        chk("hold_stuck", 2, int'(stk[2]), TMO ? 1 : 0);
        chk("hold_stuck_level", 2, int'(stl[2]), TMO ? 1 : 0);
        drive(1'b1, 10);
        drive(1'b0, 5);
        drive(1'b1, 5);
        chk("recover_stuck", 2, int'(stk[2]), 0);
        chk("recover_period", 2, int'(pc2), TMO ? 16 : 63);
        chk("recover_ovf", 2, int'(ov[2]), TMO ? 0 : 1);
        drive(1'b0, 5);
        drive(1'b1, 6);
        chk("final_high", 0, int'(hc0), 5);
        chk("final_period", 0, int'(pc0), 10);
        chk("final_dec", 0, int'(dd[0]), 1);
        chk("final_dec", 2, int'(dd[2]), TMO ? 0 : 1);
        drive(1'b0, 6);
        drive(1'b0, 4);

        // publishes captured on instance 0 since the mid-cycle reset
        chk("pub_count", 0, q_hc.size(), 25);
        chk("ramp_first_high", 0, q_hc[0], 1);
        chk("ramp_first_dir", 0, q_inc[0] + q_dec[0], 0);
        chk("ramp_second_high", 0, q_hc[1], 2);
        chk("ramp_second_inc", 0, q_inc[1], 1);
        chk("ramp_top_high", 0, q_hc[14], 15);
        chk("ramp_top_inc", 0, q_inc[14], 1);
        chk("step_down_high", 0, q_hc[15], 14);
        chk("step_down_dec", 0, q_dec[15], 1);
        chk("ext_short_high", 0, q_hc[16], 1);
        chk("ext_short_period", 0, q_pc[16], 2);
        chk("ext_short_spacing", 0, q_t[17] - q_t[16], 2);
        chk("ext_long_high", 0, q_hc[20], 15);
        chk("ext_long_period", 0, q_pc[20], 16);
        chk("ext_long_inc", 0, q_inc[20], 1);
        chk("ext_long_spacing", 0, q_t[21] - q_t[20], 16);
        chk("long_high", 0, q_hc[23], 100);
        chk("long_period", 0, q_pc[23], 105);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
